// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end for one shared signed fixed-point
// multiplier. Requesters present operand pairs with valid/ready; one pair is
// accepted at a time, multiplied, shifted down by the fraction bits,
// saturated to width bits, and returned with the owner's id on a single
// backpressured response port.
//
// Ports
//   clk, reset            : clock, async active-high reset
//   req_valid[num_req]    : requester i presents a pair
//   req_a/req_b           : operands, requester i at [i*width +: width]
//   req_ready[num_req]    : one-hot accept (IDLE only)
//   resp_valid/resp_ready : response handshake
//   resp_z, resp_id       : saturated product and owning requester
//   resp_sat              : product was clipped
module mult_arbiter #(
  parameter int width    = 16,
  parameter int int_bits = 5,
  parameter int num_req  = 4,
  localparam int iw      = (num_req > 1) ? $clog2(num_req) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [num_req-1:0]       req_valid,
  input  logic [num_req*width-1:0] req_a,
  input  logic [num_req*width-1:0] req_b,
  output logic [num_req-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [width-1:0]         resp_z,
  output logic [iw-1:0]            resp_id,
  output logic                     resp_sat
);
  localparam int f  = width - 1 - int_bits;
  localparam int pw = 2 * width;

  // Representable range of the result, extended to product width.
  localparam logic signed [pw-1:0] zmax = {{(width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [pw-1:0] zmin = {{(width+1){1'b1}}, {(width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state, state_nxt;

  logic [num_req-1:0][width-1:0] a_vec, b_vec;
  assign a_vec = req_a;
  assign b_vec = req_b;

  logic [iw-1:0]            ptr, win, win_inc, op_id;
  logic                     found, accept;
  logic [2*num_req-1:0]     dbl;
  logic [num_req-1:0]       rot;
  logic signed [width-1:0]  op_a, op_b;
  logic signed [pw-1:0]     prod, shf;
  logic [width-1:0]         z_c;
  logic                     sat_c;

  // Rotate the request vector so bit 0 is the requester at ptr; the first
  // set bit of the rotated vector is the round-robin winner.
  assign dbl = {req_valid, req_valid} >> ptr;
  assign rot = dbl[num_req-1:0];

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < num_req; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = iw'((int'(ptr) + k) % num_req);
      end
    end
  end

  assign win_inc = (win == iw'(num_req - 1)) ? '0 : win + 1'b1;
  assign accept  = (state == IDLE) && found;

  // Grant is combinational from valid/state/ptr, forced off during reset.
  always_comb begin
    req_ready = '0;
    if (accept && !reset) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)      state_nxt = CALC;
      CALC:                    state_nxt = HOLD;
      HOLD:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  assign resp_valid = (state == HOLD);

  // Sign-extend to full width so the unsigned multiply yields the exact
  // two's-complement product.
  assign prod = {{width{op_a[width-1]}}, op_a} * {{width{op_b[width-1]}}, op_b};
  assign shf  = prod >>> f;

  always_comb begin
    z_c   = shf[width-1:0];
    sat_c = 1'b0;
    if (shf > zmax) begin
      z_c   = {1'b0, {(width-1){1'b1}}};
      sat_c = 1'b1;
    end else if (shf < zmin) begin
      z_c   = {1'b1, {(width-1){1'b0}}};
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      resp_z   <= '0;
      resp_id  <= '0;
      resp_sat <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= a_vec[win];
        op_b  <= b_vec[win];
        op_id <= win;
        ptr   <= win_inc;
      end
      if (state == CALC) begin
        resp_z   <= z_c;
        resp_sat <= sat_c;
        resp_id  <= op_id;
      end
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_z;
  logic [1:0]  resp_id;
  logic        resp_sat;

  int checks = 0;
  int errors = 0;

  mult_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_id(resp_id), .resp_sat(resp_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] z;
    logic        sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
  endtask

  // Returns at 1 time unit after a falling edge in a cycle where a grant shows.
  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int c = 0; c < 20 && g == 0; c++) begin
      #1;
      g = req_ready;
      if (g == 0) @(negedge clk);
    end
    chk("grant_seen", {31'b0, g != 0}, 32'd1);
  endtask

  task automatic wait_resp();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      seen = resp_valid;
      if (!seen) @(negedge clk);
    end
    chk("resp_seen", {31'b0, seen}, 32'd1);
  endtask

  // Single isolated operation with resp_ready high; checks exact latency.
  task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] z, input logic sat);
    logic [3:0] g;
    set_op(id, a, b);
    req_valid[id] = 1'b1;
    wait_grant(g);
    chk($sformatf("op%0d_grant", id), 32'(g), 32'(4'b1 << id));
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1 chk("calc_no_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("hold_valid", 32'(resp_valid), 32'd1);
    chk($sformatf("z_%h_%h", a, b), 32'(resp_z), 32'(z));
    chk($sformatf("sat_%h_%h", a, b), 32'(resp_sat), 32'(sat));
    chk("resp_id", 32'(resp_id), 32'(id));
    @(negedge clk);
    #1 chk("back_idle", 32'(resp_valid), 32'd0);
  endtask

  logic [15:0] p3_z [4];
  int          ord3 [5];
  int          ord4 [6];
  logic [3:0]  g;

  initial begin
    vecs[0] = '{0, 16'h5500, 16'h0080, 16'h0AA0, 1'b0};
    vecs[1] = '{1, 16'h5500, 16'hFF80, 16'hF560, 1'b0};
    vecs[2] = '{1, 16'h0600, 16'h8800, 16'h8000, 1'b1};
    vecs[3] = '{1, 16'h0600, 16'h5820, 16'h7FFF, 1'b1};
    vecs[4] = '{1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[5] = '{1, 16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    vecs[6] = '{2, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0};  // floor of -1/1024
    vecs[7] = '{3, 16'h7FFF, 16'h0400, 16'h7FFF, 1'b0};  // exactly max, no clip
    p3_z = '{16'h0800, 16'hFA00, 16'h0100, 16'h7FFF};
    ord3 = '{0, 1, 2, 3, 0};
    ord4 = '{3, 2, 3, 2, 3, 0};

    reset = 1'b1; resp_ready = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_z", 32'(resp_z), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_sat", 32'(resp_sat), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    // Arithmetic vectors, one isolated op each.
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].sat);

    // All four valid out of reset: 0,1,2,3,0.
    @(negedge clk);
    reset = 1'b1;
    set_op(0, 16'h0400, 16'h0800);
    set_op(1, 16'h0C00, 16'hFE00);
    set_op(2, 16'h0200, 16'h0200);
    set_op(3, 16'h7FFF, 16'h0400);
    req_valid = 4'b1111;
    #1 chk("rst_all_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      chk($sformatf("rr_grant%0d", i), 32'(g), 32'(4'b1 << ord3[i]));
      @(posedge clk);
      @(negedge clk);
      if (i == 4) req_valid = '0;
      wait_resp();
      chk($sformatf("rr_id%0d", i), 32'(resp_id), 32'(ord3[i]));
      chk($sformatf("rr_z%0d", i), 32'(resp_z), 32'(p3_z[ord3[i]]));
    end

    // Fairness: move ptr to 3, then 2 and 3 stream; 0 joins after 4 grants.
    @(negedge clk);
    do_op(2, 16'h0200, 16'h0200, 16'h0100, 1'b0);
    req_valid = 4'b1100;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        set_op(0, 16'h0400, 16'h0800);
        req_valid[0] = 1'b1;
      end
      wait_grant(g);
      chk($sformatf("fair_grant%0d", i), 32'(g), 32'(4'b1 << ord4[i]));
      @(posedge clk);
      @(negedge clk);
      if (i == 5) req_valid = '0;
      wait_resp();
      chk($sformatf("fair_id%0d", i), 32'(resp_id), 32'(ord4[i]));
      chk($sformatf("fair_z%0d", i), 32'(resp_z), 32'(p3_z[ord4[i]]));
    end

    // Backpressure: HOLD for 10 cycles with another request pending.
    @(negedge clk);
    resp_ready = 1'b0;
    set_op(1, 16'h0400, 16'h0C00);
    req_valid[1] = 1'b1;
    wait_grant(g);
    chk("bp_grant", 32'(g), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_op(2, 16'h0100, 16'h0100);
    req_valid[2] = 1'b1;
    wait_resp();
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_z", 32'(resp_z), 32'h0C00);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("bp_one_hs", 32'(resp_valid), 32'd0);
    chk("bp_idle_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    resp_ready = 1'b1;
    wait_resp();
    chk("bp_next_id", 32'(resp_id), 32'd2);
    chk("bp_next_z", 32'(resp_z), 32'h0040);
    @(negedge clk);

    // Reset during CALC.
    set_op(1, 16'h0800, 16'h0800);
    set_op(3, 16'h0C00, 16'h0C00);
    req_valid = 4'b1010;
    wait_grant(g);
    chk("rc_grant", 32'(g), 32'b1000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rc_valid", 32'(resp_valid), 32'd0);
    chk("rc_z", 32'(resp_z), 32'd0);
    chk("rc_id", 32'(resp_id), 32'd0);
    chk("rc_sat", 32'(resp_sat), 32'd0);
    chk("rc_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rc_no_resp", 32'(resp_valid), 32'd0);
    chk("rc_ptr0_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    resp_ready = 1'b0;
    wait_resp();
    chk("rh_z_before", 32'(resp_z), 32'h1000);
    chk("rh_id_before", 32'(resp_id), 32'd1);

    // Reset during HOLD.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rh_valid", 32'(resp_valid), 32'd0);
    chk("rh_z", 32'(resp_z), 32'd0);
    chk("rh_id", 32'(resp_id), 32'd0);
    chk("rh_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp_ready = 1'b1;
    set_op(2, 16'h0400, 16'hFC00);
    req_valid = 4'b1100;
    #1;
    chk("rh_no_resp", 32'(resp_valid), 32'd0);
    chk("rh_ptr0_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_resp();
    chk("rh_next_id", 32'(resp_id), 32'd2);
    chk("rh_next_z", 32'(resp_z), 32'hFC00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter that shares one signed fixed-point multiplier among `num_req` requesters in the DNN datapath. It accepts one operand pair at a time through per-requester valid/ready handshakes and computes the saturated fixed-point product. It returns the product with the winning requester's id over a single backpressured response port. It sits between the neuron/update-stage requesters and the single multiplier resource.

## Interface

**Parameters**
- `width`, 16: operand and result width in bits, two's complement.
- `int_bits`, 5: integer bits, excluding sign. Fraction bits `F = width-1-int_bits`, which is 10 by default.
- `num_req`, 4: number of requesters, ≥2.

**Ports** (`IW = max(1, clog2(num_req))`)
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input `num_req`: bit i set means requester i presents an operand pair.
- `req_a` input `num_req*width`: operand a. Requester i uses slice `[i*width +: width]`.
- `req_b` input `num_req*width`: operand b, same slicing as `req_a`.
- `req_ready` output `num_req`: one-hot or zero. Bit i set means requester i's pair is accepted this cycle.
- `resp_valid` output 1: a result is held on the response port.
- `resp_ready` input 1: consumer accepts the result.
- `resp_z` output `width`: saturated product.
- `resp_id` output `IW`: index of the requester that owns `resp_z`.
- `resp_sat` output 1: set when saturation clipped the product.

## Operation

**FSM states**
- IDLE
  - Round-robin pick among asserted `req_valid`. Search starts at pointer `ptr` and proceeds `ptr`, `ptr+1`, … mod `num_req`.
  - Assert `req_ready` bit for the winner only, combinationally, in the same cycle.
  - On the edge where `req_valid[w] & req_ready[w]`:
    - capture `req_a[w]`, `req_b[w]` and `w` into operand registers;
    - set `ptr <= (w+1) mod num_req`;
    - go to CALC.
  - No request: stay in IDLE, `req_ready = 0`, `ptr` unchanged.
- CALC
  - Compute the product from the operand registers and register `resp_z`, `resp_sat` and `resp_id`.
  - Go to HOLD.
- HOLD
  - `resp_valid = 1`. Outputs stay stable until `resp_ready`.
  - On the edge with `resp_ready = 1`, go to IDLE.

**Behaviour outside IDLE**
- `req_ready` is 0 in CALC and HOLD.
- Requesters must hold `req_valid` and their operands stable until they see `req_ready`. The block never drops an asserted request.

**Arithmetic**
- Form the full product `P = a*b` at 2*`width` bits, signed.
- Compute `S = P >>> F`, an arithmetic shift that truncates toward −∞.
- Saturate:
  - if `S > 2^(width-1)-1`, then `resp_z = 0x7FFF`-equivalent and `resp_sat = 1`;
  - if `S < -2^(width-1)`, then `resp_z = 0x8000`-equivalent and `resp_sat = 1`;
  - otherwise `resp_z = S[width-1:0]` and `resp_sat = 0`.

**Fairness**
- A continuously requesting requester is granted within `num_req` grants.

**Reset (at any time, including mid-CALC or mid-HOLD)**
- State goes to IDLE and `ptr` to 0.
- `resp_valid`, `resp_z`, `resp_id` and `resp_sat` go to 0.
- `req_ready` is 0 while reset is asserted.
- Any in-flight operation is discarded with no response.

## Timing

**Latency**
- Accept edge at cycle t: state is CALC during cycle t+1.
- `resp_valid` is high from cycle t+2.

**Throughput**
- With `resp_ready` tied high: the response handshakes on the edge ending cycle t+2, IDLE is cycle t+3, and the next accept is at the end of cycle t+3.
- This gives one operation per 3 cycles.

**Backpressure**
- With `resp_ready` low, HOLD persists indefinitely and outputs remain stable.

**Combinational paths**
- `req_ready` depends combinationally on `req_valid`, state and `ptr`.
- No combinational path from `resp_ready` to any output.

**Simultaneous events**
- Requests arriving in CALC or HOLD wait.
- In IDLE the round-robin order decides which request wins.

## Test plan

1. **Single requester 0, `resp_ready` high.** Drive `a = 0x5500`, `b = 0x0080`.
   - Required: `resp_z = 0x0AA0` (2.65625), `resp_id = 0`, `resp_sat = 0`.
   - Required: `resp_valid` rises 2 cycles after the accept edge.
2. **Sign and saturation sequence on requester 1.**
   - `0x5500 × 0xFF80` gives `0xF560`, no saturation.
   - `0x0600 × 0x8800` gives `0x8000`, `resp_sat = 1`.
   - `0x0600 × 0x5820` gives `0x7FFF`, `resp_sat = 1`.
   - `0x8000 × 0x8000` gives `0x7FFF`, `resp_sat = 1`.
   - `0x8000 × 0x7FFF` gives `0x8000`, `resp_sat = 1`.
3. **All four requesters valid from reset, each with distinct operands.**
   - Required grant order: 0, 1, 2, 3, 0.
   - Each `resp_id` matches its grant, and each `resp_z` matches that requester's product.
4. **Fairness.** Requesters 2 and 3 are continuously valid and `ptr` is 3.
   - Required grant order: 3, 2, 3, 2.
   - Requester 0 asserts mid-sequence and is granted within 4 grants.
5. **Backpressure.** Hold `resp_ready` low for 10 cycles in HOLD.
   - Required: `resp_valid`, `resp_z` and `resp_id` are stable and `req_ready = 0` throughout.
   - Releasing `resp_ready` for one cycle gives exactly one handshake, then IDLE.
6. **Reset in CALC, then in HOLD.**
   - Required: outputs zero immediately, with no response emitted.
   - The next grant goes to the lowest-index valid requester, because `ptr` is 0.
